// File: rtl/motion_compensator_if.sv
// Predicted-pixel stream between the motion compensator and downstream reconstruction.
interface motion_compensator_if #(
  parameter int unsigned PIX_W = 8
) ();
  logic [PIX_W-1:0] pixel_out;
  logic             pixel_valid;
  logic             pixel_ready;
  logic [7:0]       pixel_index;

  modport master (
    output pixel_out,
    output pixel_valid,
    output pixel_index,
    input  pixel_ready
  );

  modport slave (
    input  pixel_out,
    input  pixel_valid,
    input  pixel_index,
    output pixel_ready
  );
endinterface

// File: rtl/motion_compensator.sv
// Reads the motion-displaced 16x16 block from the 32x32 search memory and streams it in raster order.
// Optional residual output (R - predicted pixel) is built when MC_RESIDUAL_EN is defined.
module motion_compensator #(
  parameter int unsigned BLOCK = 16,
  parameter int unsigned WIN   = 32,
  parameter int unsigned PIX_W = 8,
  parameter int unsigned MV_W  = 4
) (
  input  logic                         clock,
  input  logic                         reset_n,
  input  logic                         start,
  input  logic signed [MV_W-1:0]       motionX,
  input  logic signed [MV_W-1:0]       motionY,
  output logic [2*$clog2(WIN)-1:0]     AddressS,
  input  logic [PIX_W-1:0]             S,
`ifdef MC_RESIDUAL_EN
  output logic [2*$clog2(BLOCK)-1:0]   AddressR,
  input  logic [PIX_W-1:0]             R,
  output logic signed [PIX_W:0]        residual,
`endif
  motion_compensator_if.master         pix,
  output logic                         busy,
  output logic                         completed
);

  localparam int unsigned BW = $clog2(BLOCK);
  localparam int unsigned WW = $clog2(WIN);
  localparam int unsigned IW = 2 * BW;
  localparam logic [WW-1:0] Org = WW'((WIN - BLOCK) / 2);
`ifdef MC_RESIDUAL_EN
  localparam int unsigned EntW = PIX_W + PIX_W + 1;
`else
  localparam int unsigned EntW = PIX_W;
`endif

  typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

  state_e                 r_state, w_state_d;
  logic signed [MV_W-1:0] r_mx, r_my;
  logic [IW-1:0]          r_cnt;
  logic [IW-1:0]          r_out_idx;
  logic                   r_inflight;
  logic [1:0]             r_occ;
  logic [EntW-1:0]        r_ent0, r_ent1;

  logic                   w_pop, w_push, w_issue, w_drained;
  logic [EntW-1:0]        w_push_d;
  logic [WW-1:0]          w_ry, w_rx;

  // Window coordinates of the current raster position; always land in 0..WIN-2, so no wrap.
  assign w_ry = {{(WW-BW){1'b0}}, r_cnt[IW-1:BW]} + {{(WW-MV_W){r_my[MV_W-1]}}, r_my} + Org;
  assign w_rx = {{(WW-BW){1'b0}}, r_cnt[BW-1:0]}  + {{(WW-MV_W){r_mx[MV_W-1]}}, r_mx} + Org;

  assign w_pop  = (r_occ != 2'd0) & pix.pixel_ready;
  assign w_push = r_inflight;

  // A slot freed by this edge's pop counts as free, which sustains one pixel per cycle.
  assign w_issue = (r_state == StRun) &&
                   (({1'b0, r_occ} + {2'b00, r_inflight} - {2'b00, w_pop}) < 3'd2);

  assign w_drained = !r_inflight && ((r_occ == 2'd0) || ((r_occ == 2'd1) && w_pop));

`ifdef MC_RESIDUAL_EN
  logic [PIX_W:0] w_res;
  assign w_res    = {1'b0, R} - {1'b0, S};
  assign w_push_d = {S, w_res};
  assign residual = r_ent0[PIX_W:0];
`else
  assign w_push_d = S;
`endif

  assign pix.pixel_out   = r_ent0[EntW-1 -: PIX_W];
  assign pix.pixel_valid = (r_occ != 2'd0);
  assign pix.pixel_index = r_out_idx;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_d;
    end
  end

  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      StIdle:  if (start) w_state_d = StRun;
      StRun:   if (w_issue && (r_cnt == {IW{1'b1}})) w_state_d = StDrain;
      StDrain: if (w_drained) w_state_d = StDone;
      StDone:  w_state_d = StIdle;
      default: w_state_d = StIdle;
    endcase
  end

  always_comb begin
    busy      = (r_state == StRun) || (r_state == StDrain);
    completed = (r_state == StDone);
    AddressS  = (r_state == StRun) ? {w_ry, w_rx} : '0;
`ifdef MC_RESIDUAL_EN
    AddressR  = (r_state == StRun) ? r_cnt : '0;
`endif
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_mx       <= '0;
      r_my       <= '0;
      r_cnt      <= '0;
      r_inflight <= 1'b0;
    end else begin
      if ((r_state == StIdle) && start) begin
        r_mx  <= motionX;
        r_my  <= motionY;
        r_cnt <= '0;
      end else if (w_issue) begin
        r_cnt <= r_cnt + IW'(1);
      end
      r_inflight <= w_issue;
    end
  end

  // Two-entry shift FIFO; r_ent0 is always the head.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_occ     <= 2'd0;
      r_ent0    <= '0;
      r_ent1    <= '0;
      r_out_idx <= '0;
    end else begin
      if (w_push && !w_pop) begin
        if (r_occ == 2'd0) r_ent0 <= w_push_d;
        else               r_ent1 <= w_push_d;
        r_occ <= r_occ + 2'd1;
      end else if (w_pop && !w_push) begin
        r_ent0 <= r_ent1;
        r_occ  <= r_occ - 2'd1;
      end else if (w_push && w_pop) begin
        if (r_occ == 2'd1) begin
          r_ent0 <= w_push_d;
        end else begin
          r_ent0 <= r_ent1;
          r_ent1 <= w_push_d;
        end
      end
      if ((r_state == StIdle) && start) begin
        r_out_idx <= '0;
      end else if (w_pop) begin
        r_out_idx <= r_out_idx + IW'(1);
      end
    end
  end

endmodule

// File: tb/tb_motion_compensator.sv
// Self-checking bench for motion_compensator: vector table of runs plus a pixel scoreboard queue.
module tb_motion_compensator;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic       start = 1'b0;
  logic [3:0] motionX = '0;
  logic [3:0] motionY = '0;
  logic [9:0] AddressS;
  logic [7:0] S = '0;
  logic       busy;
  logic       completed;
`ifdef MC_RESIDUAL_EN
  logic [7:0] AddressR;
  logic [7:0] R = '0;
  logic [8:0] residual;
`endif

  motion_compensator_if #(.PIX_W(8)) pix ();

  motion_compensator #(
    .BLOCK(16),
    .WIN  (32),
    .PIX_W(8),
    .MV_W (4)
  ) dut (
    .clock    (clock),
    .reset_n  (reset_n),
    .start    (start),
    .motionX  (motionX),
    .motionY  (motionY),
    .AddressS (AddressS),
    .S        (S),
`ifdef MC_RESIDUAL_EN
    .AddressR (AddressR),
    .R        (R),
    .residual (residual),
`endif
    .pix      (pix.master),
    .busy     (busy),
    .completed(completed)
  );

  always #5 clock = ~clock;

  logic [7:0] smem [1024];
  logic [7:0] rmem [256];

  always @(posedge clock) S <= smem[AddressS];
`ifdef MC_RESIDUAL_EN
  always @(posedge clock) R <= rmem[AddressR];
`endif

  typedef struct {
    logic [7:0] idx;
    logic [7:0] pix;
    logic [8:0] res;
  } exp_t;

  typedef struct {
    int mx;
    int my;
    int mode;      // 0: ready=1, 1: alternating, 2: alternating + 20-cycle stall at pixel 100
    bit inj;       // stray start pulses at pixels 10 and 200
    int abort_at;  // pixel index at which reset is pulsed, -1 for none
    int a0;
    int a255;
    int first_t;
    int done_t;
  } vec_t;

  exp_t q[$];
  vec_t vt[9];
  int   n_vec  = 0;
  int   n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v);
    int t = 0;
    int acc = 0;
    int ncomp = 0;
    int first_t = -1;
    int done_t = -1;
    int stall = 0;
    bit stalled = 1'b0;
    bit hold = 1'b0;
    bit inj10 = 1'b0;
    bit inj200 = 1'b0;
    bit aborted = 1'b0;
    logic [7:0] h_pix, h_idx;
    logic [3:0] mx4, my4;
    exp_t e;

    for (int k = 0; k < 256; k++) begin
      int a;
      a = 264 + ((k / 16) + v.my) * 32 + ((k % 16) + v.mx);
      e.idx = 8'(k);
      e.pix = smem[a];
      e.res = {1'b0, rmem[k]} - {1'b0, smem[a]};
      q.push_back(e);
    end

    mx4 = v.mx[3:0];
    my4 = v.my[3:0];
    @(negedge clock);
    motionX = mx4;
    motionY = my4;
    start   = 1'b1;
    pix.pixel_ready = 1'b1;

    while ((t < 1500) && (done_t < 0) && !aborted) begin
      @(negedge clock);
      t++;
      start = 1'b0;
      if (t == 1) begin
        check("busy_after_start", 32'(busy), 32'd1);
        check("addr_pixel0", 32'(AddressS), 32'(v.a0));
      end

      case (v.mode)
        0: pix.pixel_ready = 1'b1;
        1: pix.pixel_ready = t[0];
        default: begin
          if (stall > 0) begin
            pix.pixel_ready = 1'b0;
            stall--;
          end else if (!stalled && pix.pixel_valid && (pix.pixel_index == 8'd100)) begin
            stalled = 1'b1;
            stall = 19;
            pix.pixel_ready = 1'b0;
          end else begin
            pix.pixel_ready = t[0];
          end
        end
      endcase

      if (v.inj && pix.pixel_valid) begin
        if ((pix.pixel_index == 8'd10 && !inj10) || (pix.pixel_index == 8'd200 && !inj200)) begin
          if (pix.pixel_index == 8'd10) inj10 = 1'b1;
          else                          inj200 = 1'b1;
          start   = 1'b1;
          motionX = 4'($urandom);
          motionY = 4'($urandom);
        end
      end

      if ((v.abort_at >= 0) && pix.pixel_valid && (int'(pix.pixel_index) == v.abort_at)) begin
        aborted = 1'b1;
        reset_n = 1'b0;
        #1;
        check("abort_addr", 32'(AddressS), 32'd0);
        check("abort_pixel", 32'(pix.pixel_out), 32'd0);
        check("abort_valid", 32'(pix.pixel_valid), 32'd0);
        check("abort_index", 32'(pix.pixel_index), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        for (int i = 0; i < 2; i++) begin
          @(negedge clock);
          check("abort_no_completed", 32'(completed), 32'd0);
        end
        reset_n = 1'b1;
        @(negedge clock);
        check("abort_idle_completed", 32'(completed), 32'd0);
        check("abort_idle_busy", 32'(busy), 32'd0);
      end else begin
        if (hold) begin
          check("stall_valid", 32'(pix.pixel_valid), 32'd1);
          check("stall_pixel", 32'(pix.pixel_out), 32'(h_pix));
          check("stall_index", 32'(pix.pixel_index), 32'(h_idx));
        end
        if (pix.pixel_valid && (first_t < 0)) first_t = t;
        if (pix.pixel_valid && pix.pixel_ready) begin
          if (q.size() == 0) begin
            check("extra_pixel", 32'(pix.pixel_index), 32'hFFFF);
          end else begin
            e = q.pop_front();
            check("pixel_index", 32'(pix.pixel_index), 32'(e.idx));
            check("pixel_value", 32'(pix.pixel_out), 32'(e.pix));
`ifdef MC_RESIDUAL_EN
            check("residual", 32'(residual), 32'(e.res));
            if ((v.mx == -4) && (v.my == 6)) check("residual_zero", 32'(residual), 32'd0);
`endif
            if (acc == 0)   check("first_pixel_mem", 32'(pix.pixel_out), 32'(smem[v.a0]));
            if (acc == 255) check("last_pixel_mem", 32'(pix.pixel_out), 32'(smem[v.a255]));
          end
          acc++;
        end
        hold  = pix.pixel_valid && !pix.pixel_ready;
        h_pix = pix.pixel_out;
        h_idx = pix.pixel_index;
        if (completed) begin
          ncomp++;
          done_t = t;
          check("busy_low_at_done", 32'(busy), 32'd0);
        end
      end
    end

    if (!aborted) begin
      if (done_t < 0) begin
        n_vec++;
        n_fail++;
        $display("FAIL run_timeout: no completed pulse within %0d cycles, mv=(%0d,%0d)",
                 t, v.mx, v.my);
      end
      check("pixels_accepted", 32'(acc), 32'd256);
      if (v.first_t > 0) check("first_valid_cycle", 32'(first_t), 32'(v.first_t));
      if (v.done_t > 0)  check("completed_cycle", 32'(done_t), 32'(v.done_t));
      for (int i = 0; i < 3; i++) begin
        @(negedge clock);
        if (completed) ncomp++;
      end
      check("completed_pulses", 32'(ncomp), 32'd1);
      check("idle_busy", 32'(busy), 32'd0);
      check("idle_valid", 32'(pix.pixel_valid), 32'd0);
    end
    q.delete();
  endtask

  initial begin
    pix.pixel_ready = 1'b1;
    for (int i = 0; i < 1024; i++) smem[i] = 8'($urandom);
    for (int k = 0; k < 256; k++) rmem[k] = smem[264 + ((k / 16) + 6) * 32 + ((k % 16) - 4)];

    vt[0] = '{mx:  0, my:  0, mode: 0, inj: 1'b0, abort_at:  -1, a0: 264, a255: 759,
              first_t: 3, done_t: 259};
    vt[1] = '{mx: -8, my: -8, mode: 0, inj: 1'b0, abort_at:  -1, a0:   0, a255: 495,
              first_t: 3, done_t: 259};
    vt[2] = '{mx:  7, my:  7, mode: 0, inj: 1'b0, abort_at:  -1, a0: 495, a255: 990,
              first_t: 3, done_t: 259};
    vt[3] = '{mx:  3, my: -5, mode: 2, inj: 1'b0, abort_at:  -1, a0: 107, a255: 602,
              first_t: 3, done_t: -1};
    vt[4] = '{mx:  2, my: -3, mode: 0, inj: 1'b1, abort_at:  -1, a0: 170, a255: 665,
              first_t: 3, done_t: 259};
    vt[5] = '{mx:  5, my:  1, mode: 1, inj: 1'b0, abort_at:  -1, a0: 301, a255: 796,
              first_t: 3, done_t: -1};
    vt[6] = '{mx: -2, my:  4, mode: 0, inj: 1'b0, abort_at: 100, a0: 390, a255: 885,
              first_t: -1, done_t: -1};
    vt[7] = '{mx:  1, my:  2, mode: 0, inj: 1'b0, abort_at:  -1, a0: 329, a255: 824,
              first_t: 3, done_t: 259};
    vt[8] = '{mx: -4, my:  6, mode: 0, inj: 1'b0, abort_at:  -1, a0: 452, a255: 947,
              first_t: 3, done_t: 259};

    repeat (3) @(negedge clock);
    check("reset_addr", 32'(AddressS), 32'd0);
    check("reset_pixel", 32'(pix.pixel_out), 32'd0);
    check("reset_valid", 32'(pix.pixel_valid), 32'd0);
    check("reset_index", 32'(pix.pixel_index), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_completed", 32'(completed), 32'd0);
`ifdef MC_RESIDUAL_EN
    check("reset_residual", 32'(residual), 32'd0);
`endif
    reset_n = 1'b1;
    repeat (2) @(negedge clock);

    for (int i = 0; i < 9; i++) run_vec(vt[i]);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/motion_compensator.md
Name: motion_compensator

Overview:
- Decoder-side partner of the full-search motion estimator: takes a motion vector (motionX, motionY) and reads the displaced 16x16 block out of the 32x32 search memory.
- Streams the predicted block as 256 raster-order pixels over a valid/ready interface.
- Sits between the search memory (synchronous read, 1-cycle latency) and downstream reconstruction logic.
- Vector encoding, window origin and address map match the estimator's.

Parameters:
- BLOCK, 16, reference block edge in pixels.
- WIN, 32, search window edge in pixels.
- PIX_W, 8, pixel width in bits.
- MV_W, 4, motion component width (two's complement, range -8..+7).

Ports:
- clock  in  1  rising-edge clock
- reset_n  in  1  asynchronous active-low reset
- start  in  1  request; sampled only in IDLE
- motionX  in  MV_W  signed horizontal displacement; latched with start
- motionY  in  MV_W  signed vertical displacement; latched with start
- AddressS  out  10  search memory read address
- S  in  PIX_W  search memory data; reflects AddressS sampled at previous edge
- pixel_out  out  PIX_W  predicted pixel
- pixel_valid  out  1  pixel_out valid
- pixel_ready  in  1  downstream accepts pixel when valid and ready on the same edge
- pixel_index  out  8  raster index (row*16+col) of pixel_out
- busy  out  1  high from start acceptance until completion
- completed  out  1  one-cycle pulse after the last pixel is accepted

Behaviour:
- Reset (async, reset_n=0): state IDLE; AddressS=0, pixel_out=0, pixel_valid=0, pixel_index=0, busy=0, completed=0; FIFO emptied; in-flight read discarded.
- Address: AddressS = 264 + (row+my)*32 + (col+mx), with mx/my sign-extended and row,col in 0..15. Origin 264 = 8*32+8. Result is always within 0..1023; no clamping.
- FSM states: IDLE, RUN, DRAIN, DONE.
- IDLE: start=1 at an edge latches motionX/motionY, clears the counter, sets busy, goes to RUN.
- start is ignored in every state other than IDLE.
- Issue rule: RUN issues one address per cycle while (FIFO occupancy + in-flight reads) < 2.
- Buffering: returned S data is written into a 2-entry FIFO on the edge after it is valid. The FIFO head drives pixel_out, pixel_valid and pixel_index.
- Counter: 8-bit raster counter advances on each issue. RUN goes to DRAIN after index 255 is issued.
- DRAIN: waits until the FIFO is empty and no read is in flight, then goes to DONE.
- DONE: completed=1 and busy=0 for exactly one cycle, then IDLE.
- Latency: start sampled at edge E0; address 0 driven after E0; S valid after E1; pixel 0 valid after E2.
- Throughput: with pixel_ready held 1, one pixel per cycle. Pixel 255 is accepted at E258; completed is high after E258.
- Backpressure: while pixel_ready=0, pixel_out, pixel_valid and pixel_index hold stable. No pixel is dropped or duplicated, and order is strict raster.
- Simultaneous events: a FIFO push and pop on the same edge keep occupancy unchanged.
- Reset mid-operation: abort immediately; no completed pulse. The next start begins from pixel 0.

Optional Feature:
- Macro: MC_RESIDUAL_EN.
- Defined, extra ports:
  - AddressR  out  8  reference memory read address
  - R  in  PIX_W  reference memory data
  - residual  out  PIX_W+1  signed difference
- Defined, behaviour: AddressR equals the raster counter and is issued alongside AddressS. residual = R - predicted pixel as 9-bit two's complement, carried in the same FIFO entry and valid with pixel_valid. residual resets to 0.
- Undefined: those ports do not exist and no residual logic is built. All other behaviour is identical.

Test Plan:
- Zero vector: Smem random, mv=(0,0), ready=1 -> pixel k = Smem[264+(k/16)*32+k%16] for all 256 pixels; pixel 0 valid after E2; completed pulses after E258.
- Corner vectors: mv=(-8,-8) -> pixel0=Smem[0], pixel255=Smem[495]; mv=(+7,+7) -> pixel0=Smem[495], pixel255=Smem[990].
- Backpressure: mv=(3,-5), pixel_ready alternating 1/0 plus a 20-cycle low stall at pixel 100 -> 256 pixels in order, none missing or repeated, pixel_index continuous 0..255, outputs stable while stalled.
- Busy start: start pulses at pixels 10 and 200 of a run -> ignored; exactly 256 pixels and one completed pulse; a start in IDLE after completion launches a new run.
- Reset abort: reset_n low for 2 cycles at pixel 100 -> all outputs 0, no completed pulse; next start with mv=(1,2) produces a full correct 256-pixel block.
- MC_RESIDUAL_EN: Rmem extracted from Smem with offset (-4,6), mv=(-4,6) -> residual=0 for all 256 pixels; mv=(0,0) -> residual k = Rmem[k] - pixel k, sign-correct.
